// File: rtl/titles_pkg.sv
// Shared definitions for the titles overlay engine:
// mode encodings, coordinate width and the default transparent colour.
package titles_pkg;

    localparam int COORD_W = 11;
    localparam logic [7:0] TRANSPARENT_DEF = 8'hFF;

    typedef enum logic [1:0] {
        MODE_ALWAYS  = 2'b00,
        MODE_PLAY    = 2'b01,
        MODE_NONPLAY = 2'b10,
        MODE_BLINK   = 2'b11
    } mode_e;

    function automatic logic mode_enable(
        input mode_e m,
        input logic  play,
        input logic  phase
    );
        logic en;
        en = 1'b0;
        unique case (m)
            MODE_ALWAYS:  en = 1'b1;
            MODE_PLAY:    en = play;
            MODE_NONPLAY: en = ~play;
            MODE_BLINK:   en = ~play & ~phase;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/title_hit_detect.sv
// Box compare for one title channel plus the glyph offsets of the
// current pixel relative to the channel origin.
module title_hit_detect
    import titles_pkg::*;
#(
    parameter int TITLE_W = 128,
    parameter int TITLE_H = 16,
    parameter int OX_W    = 7,
    parameter int OY_W    = 4
) (
    input  logic [COORD_W-1:0] i_pixel_x,
    input  logic [COORD_W-1:0] i_pixel_y,
    input  logic [COORD_W-1:0] i_origin_x,
    input  logic [COORD_W-1:0] i_origin_y,
    output logic               o_hit,
    output logic [OX_W-1:0]    o_off_x,
    output logic [OY_W-1:0]    o_off_y
);

    // One extra bit so boxes whose origin is near 2047 never wrap.
    logic [COORD_W:0] w_px;
    logic [COORD_W:0] w_py;
    logic [COORD_W:0] w_x0;
    logic [COORD_W:0] w_y0;
    logic [COORD_W:0] w_x1;
    logic [COORD_W:0] w_y1;
    logic [COORD_W-1:0] w_dx;
    logic [COORD_W-1:0] w_dy;
    logic w_in_x;
    logic w_in_y;

    assign w_px = {1'b0, i_pixel_x};
    assign w_py = {1'b0, i_pixel_y};
    assign w_x0 = {1'b0, i_origin_x};
    assign w_y0 = {1'b0, i_origin_y};
    assign w_x1 = w_x0 + (COORD_W+1)'(TITLE_W);
    assign w_y1 = w_y0 + (COORD_W+1)'(TITLE_H);

    assign w_in_x = (w_px >= w_x0) && (w_px < w_x1);
    assign w_in_y = (w_py >= w_y0) && (w_py < w_y1);
    assign o_hit  = w_in_x & w_in_y;

    assign w_dx = i_pixel_x - i_origin_x;
    assign w_dy = i_pixel_y - i_origin_y;

    assign o_off_x = w_dx[OX_W-1:0];
    assign o_off_y = w_dy[OY_W-1:0];

endmodule

// File: rtl/titles_overlay_engine.sv
// Multi-channel title overlay: priority box hit, external glyph ROM
// lookup and play/blink visibility, three-clock fixed latency.
module titles_overlay_engine
    import titles_pkg::*;
#(
    parameter int         NUM_TITLES   = 4,
    parameter int         TITLE_W      = 128,
    parameter int         TITLE_H      = 16,
    parameter int         BLINK_FRAMES = 30,
    parameter logic [7:0] TRANSPARENT  = TRANSPARENT_DEF,
    localparam int        OX_W  = (TITLE_W > 1) ? $clog2(TITLE_W) : 1,
    localparam int        OY_W  = (TITLE_H > 1) ? $clog2(TITLE_H) : 1,
    localparam int        CNT_W = $clog2(BLINK_FRAMES)
) (
    input  logic                          clk,
    input  logic                          resetN,
    input  logic                          startOfFrame,
    input  logic                          gameEnded,
    input  logic                          standBy,
    input  logic [COORD_W-1:0]            pixelX,
    input  logic [COORD_W-1:0]            pixelY,
    input  logic [NUM_TITLES*COORD_W-1:0] cfgTopLeftX,
    input  logic [NUM_TITLES*COORD_W-1:0] cfgTopLeftY,
    input  logic [NUM_TITLES*2-1:0]       cfgMode,
    output logic [2:0]                    romTitleIdx,
    output logic [OX_W-1:0]               romOffsetX,
    output logic [OY_W-1:0]               romOffsetY,
    input  logic [7:0]                    romRGB,
    output logic                          titlesDR,
    output logic [7:0]                    titlesRGB
);

    logic             r_play;
    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;

    logic             r_hit1;
    logic             r_hit2;
    logic [2:0]       r_idx;
    logic [OX_W-1:0]  r_offx;
    logic [OY_W-1:0]  r_offy;
    logic             r_dr;
    logic [7:0]       r_rgb;

    logic                  w_play_game;
    logic [NUM_TITLES-1:0] w_hit;
    logic [NUM_TITLES-1:0] w_en;
    logic [OX_W-1:0]       w_offx [NUM_TITLES];
    logic [OY_W-1:0]       w_offy [NUM_TITLES];
    logic                  w_any;
    logic [2:0]            w_sel;
    logic [OX_W-1:0]       w_selx;
    logic [OY_W-1:0]       w_sely;
    logic                  w_opaque;

    assign w_play_game = ~(gameEnded | standBy);

    for (genvar i = 0; i < NUM_TITLES; i++) begin : g_ch
        title_hit_detect #(
            .TITLE_W (TITLE_W),
            .TITLE_H (TITLE_H),
            .OX_W    (OX_W),
            .OY_W    (OY_W)
        ) u_hit (
            .i_pixel_x  (pixelX),
            .i_pixel_y  (pixelY),
            .i_origin_x (cfgTopLeftX[i*COORD_W +: COORD_W]),
            .i_origin_y (cfgTopLeftY[i*COORD_W +: COORD_W]),
            .o_hit      (w_hit[i]),
            .o_off_x    (w_offx[i]),
            .o_off_y    (w_offy[i])
        );

        assign w_en[i] = w_hit[i] &
            mode_enable(mode_e'(cfgMode[i*2 +: 2]), r_play, r_phase);
    end

    // Walk from the highest index down so the lowest enabled one wins.
    always_comb begin
        w_any  = 1'b0;
        w_sel  = '0;
        w_selx = '0;
        w_sely = '0;
        for (int i = NUM_TITLES - 1; i >= 0; i--) begin
            if (w_en[i]) begin
                w_any  = 1'b1;
                w_sel  = 3'(i);
                w_selx = w_offx[i];
                w_sely = w_offy[i];
            end
        end
    end

    // A 1->0 play edge is seen while r_play is still 1, so blinking
    // restarts from a cleared counter and visible phase.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_play  <= 1'b0;
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else begin
            if (startOfFrame) begin
                r_play <= w_play_game;
            end
            if (r_play) begin
                r_cnt   <= '0;
                r_phase <= 1'b0;
            end else if (startOfFrame) begin
                if (r_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                    r_cnt   <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign w_opaque = (romRGB != TRANSPARENT);

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_hit1 <= 1'b0;
            r_hit2 <= 1'b0;
            r_idx  <= '0;
            r_offx <= '0;
            r_offy <= '0;
            r_dr   <= 1'b0;
            r_rgb  <= 8'h00;
        end else begin
            r_hit1 <= w_any;
            if (w_any) begin
                r_idx  <= w_sel;
                r_offx <= w_selx;
                r_offy <= w_sely;
            end
            r_hit2 <= r_hit1;
            r_dr   <= r_hit2 & w_opaque;
            r_rgb  <= (r_hit2 & w_opaque) ? romRGB : 8'h00;
        end
    end

    assign romTitleIdx = r_idx;
    assign romOffsetX  = r_offx;
    assign romOffsetY  = r_offy;
    assign titlesDR    = r_dr;
    assign titlesRGB   = r_rgb;

endmodule

// File: tb/tb_titles_overlay_engine.sv
// Randomised and directed bench for titles_overlay_engine against a
// frame-level reference model with a behavioural glyph ROM.
module tb_titles_overlay_engine;

    localparam int NT = 4;
    localparam int TW = 128;
    localparam int TH = 16;
    localparam int BF = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             resetN;
    logic             sof;
    logic             ge;
    logic             sb;
    logic [10:0]      px;
    logic [10:0]      py;
    logic [NT*11-1:0] cfx;
    logic [NT*11-1:0] cfy;
    logic [NT*2-1:0]  cfm;
    logic [2:0]       ridx;
    logic [6:0]       rox;
    logic [3:0]       roy;
    logic [7:0]       rrgb;
    logic             dr;
    logic [7:0]       rgb;

    titles_overlay_engine #(
        .NUM_TITLES   (NT),
        .TITLE_W      (TW),
        .TITLE_H      (TH),
        .BLINK_FRAMES (BF),
        .TRANSPARENT  (8'hFF)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (sof),
        .gameEnded    (ge),
        .standBy      (sb),
        .pixelX       (px),
        .pixelY       (py),
        .cfgTopLeftX  (cfx),
        .cfgTopLeftY  (cfy),
        .cfgMode      (cfm),
        .romTitleIdx  (ridx),
        .romOffsetX   (rox),
        .romOffsetY   (roy),
        .romRGB       (rrgb),
        .titlesDR     (dr),
        .titlesRGB    (rgb)
    );

    typedef struct {
        logic       dr;
        logic [7:0] rgb;
        string      tag;
    } exp_t;

    exp_t  q[$];
    int    cx[NT];
    int    cy[NT];
    int    cm[NT];
    int    n_cmp = 0;
    int    n_err = 0;
    bit    m_play = 1'b0;
    int    m_frames = 0;
    string g_tag = "reset";

    function automatic logic [7:0] rom_val(int idx, int ox, int oy);
        if (idx == 0 && ox == 0 && oy == 0) return 8'h5b;
        if ((ox + 2 * oy + idx) % 9 == 4) return 8'hFF;
        return 8'((idx * 53 + ox * 7 + oy * 29 + 1) % 255);
    endfunction

    always @(posedge clk)
        rrgb <= rom_val(int'(ridx), int'(rox), int'(roy));

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_px();
        exp_t e;
        bit   phase;
        bit   en;
        int   x;
        int   y;
        logic [7:0] v;
        e.dr  = 1'b0;
        e.rgb = 8'h00;
        e.tag = g_tag;
        phase = ((m_frames / BF) % 2) == 1;
        x = int'(px);
        y = int'(py);
        for (int i = 0; i < NT; i++) begin
            case (cm[i])
                0:       en = 1'b1;
                1:       en = m_play;
                2:       en = !m_play;
                default: en = !m_play && !phase;
            endcase
            if (en && x >= cx[i] && x < cx[i] + TW &&
                y >= cy[i] && y < cy[i] + TH) begin
                v = rom_val(i, x - cx[i], y - cy[i]);
                if (v != 8'hFF) begin
                    e.dr  = 1'b1;
                    e.rgb = v;
                end
                return e;
            end
        end
        return e;
    endfunction

    // Called just after a falling edge with the cycle's inputs chosen.
    task automatic step();
        exp_t e;
        bit   nb;
        for (int i = 0; i < NT; i++) begin
            cfx[i*11 +: 11] = 11'(cx[i]);
            cfy[i*11 +: 11] = 11'(cy[i]);
            cfm[i*2 +: 2]   = 2'(cm[i]);
        end
        e = model_px();
        if (!resetN) begin
            e.dr  = 1'b0;
            e.rgb = 8'h00;
            foreach (q[k]) begin
                q[k].dr  = 1'b0;
                q[k].rgb = 8'h00;
            end
            m_play   = 1'b0;
            m_frames = 0;
        end else if (sof) begin
            nb = !(ge || sb);
            if (m_play && !nb) m_frames = 0;
            else if (!m_play) m_frames++;
            m_play = nb;
        end
        q.push_back(e);
        @(negedge clk);
        if (q.size() >= 3) begin
            e = q.pop_front();
            chk({e.tag, "_dr"}, 32'(dr), 32'(e.dr));
            chk({e.tag, "_rgb"}, 32'(rgb), 32'(e.rgb));
        end
    endtask

    task automatic set_ch(int i, int x, int y, int m);
        cx[i] = x;
        cy[i] = y;
        cm[i] = m;
    endtask

    task automatic park_all();
        for (int i = 0; i < NT; i++) set_ch(i, 1800, 1800, 0);
    endtask

    task automatic pix(int x, int y, string tag);
        px    = 11'(x);
        py    = 11'(y);
        g_tag = tag;
        step();
    endtask

    initial begin
        int c;
        int dx;
        int dy;
        resetN = 1'b0;
        sof = 1'b0;
        ge  = 1'b0;
        sb  = 1'b0;
        px  = '0;
        py  = '0;
        park_all();
        @(negedge clk);

        for (int k = 0; k < 3; k++) pix(0, 0, "reset");
        chk("rst_idx", 32'(ridx), 32'd0);
        chk("rst_offx", 32'(rox), 32'd0);
        chk("rst_offy", 32'(roy), 32'd0);
        resetN = 1'b1;

        // Single-pixel hit, right edge exclusion.
        set_ch(0, 30, 11, 0);
        pix(30, 11, "req041");
        pix(158, 11, "req042");
        pix(157, 26, "in_corner");
        pix(30, 27, "below_box");
        for (int k = 0; k < 3; k++) pix(0, 0, "idle");

        // Overlap priority.
        set_ch(0, 40, 440, 0);
        set_ch(1, 20, 445, 0);
        pix(50, 450, "req043");
        chk("req043_idx", 32'(ridx), 32'd0);
        chk("req043_offx", 32'(rox), 32'd10);
        chk("req043_offy", 32'(roy), 32'd10);
        pix(25, 446, "ch1_only");
        chk("ch1_idx", 32'(ridx), 32'd1);
        pix(0, 0, "idle");

        // Play-only title across a mid-frame game over.
        park_all();
        set_ch(0, 100, 100, 1);
        sof = 1'b1;
        pix(0, 0, "req045_sof");
        sof = 1'b0;
        for (int k = 0; k < 5; k++) pix(101 + 2 * k, 100, "req045_play");
        ge = 1'b1;
        for (int k = 0; k < 5; k++) pix(101 + 2 * k, 100, "req045_mid");
        sof = 1'b1;
        pix(101, 100, "req045_sofedge");
        sof = 1'b0;
        for (int k = 0; k < 5; k++) pix(101 + 2 * k, 100, "req045_after");
        ge = 1'b0;

        // Blink in standby, starting from a play frame.
        set_ch(0, 100, 100, 3);
        sof = 1'b1;
        pix(0, 0, "req044_play");
        sof = 1'b0;
        pix(0, 0, "req044_play");
        sb = 1'b1;
        for (int f = 0; f < 6; f++) begin
            sof = 1'b1;
            pix(0, 0, $sformatf("req044_f%0d_sof", f));
            sof = 1'b0;
            for (int k = 0; k < 3; k++)
                pix(101 + 2 * k, 101, $sformatf("req044_f%0d", f));
        end
        sb = 1'b0;

        // One-clock reset while drawing.
        set_ch(0, 100, 100, 0);
        set_ch(1, 300, 100, 1);
        sof = 1'b1;
        pix(101, 100, "req046_pre");
        sof = 1'b0;
        for (int k = 0; k < 3; k++) pix(301 + 2 * k, 100, "req046_pre");
        resetN = 1'b0;
        pix(103, 100, "req046_rst");
        resetN = 1'b1;
        for (int k = 0; k < 4; k++) pix(101 + 2 * k, 100, "req046_post");
        for (int k = 0; k < 4; k++) pix(301 + 2 * k, 100, "req046_ch1");

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            if (n % 64 == 0) begin
                for (int i = 0; i < NT; i++) begin
                    if ($urandom_range(0, 3) == 0)
                        cx[i] = int'($urandom_range(1900, 2047));
                    else
                        cx[i] = int'($urandom_range(0, 600));
                    if ($urandom_range(0, 3) == 0)
                        cy[i] = int'($urandom_range(2020, 2047));
                    else
                        cy[i] = int'($urandom_range(0, 500));
                    cm[i] = int'($urandom_range(0, 3));
                end
            end
            sof = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) ge = ~ge;
            if ($urandom_range(0, 31) == 0) sb = ~sb;
            resetN = ($urandom_range(0, 199) != 0);
            c  = int'($urandom_range(0, NT - 1));
            dx = int'($urandom_range(0, TW + 15)) - 8;
            dy = int'($urandom_range(0, TH + 7)) - 4;
            pix((cx[c] + dx) & 2047, (cy[c] + dy) & 2047, "rand");
        end

        resetN = 1'b1;
        sof = 1'b0;
        for (int k = 0; k < 3; k++) pix(0, 0, "drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/titles_overlay_engine.md
TITLES_OVERLAY_ENGINE -- requirements
Module: titles_overlay_engine

Interface
REQ-001 Parameter NUM_TITLES, default 4: number of title channels, range 1..8.
REQ-002 Parameter TITLE_W, default 128: title box width in pixels, power of two.
REQ-003 Parameter TITLE_H, default 16: title box height in pixels, power of two.
REQ-004 Parameter BLINK_FRAMES, default 30: frames per blink half-period, at least 2.
REQ-005 Parameter TRANSPARENT, default 8'hFF: ROM colour treated as "not drawn".
REQ-006 Port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-007 Port resetN, input, 1 bit: reset, synchronous, active-low.
REQ-008 Port startOfFrame, input, 1 bit: one-cycle pulse at frame start.
REQ-009 Port gameEnded, input, 1 bit: game-over status.
REQ-010 Port standBy, input, 1 bit: standby status.
REQ-011 Port pixelX, input, 11 bits: current pixel column.
REQ-012 Port pixelY, input, 11 bits: current pixel row.
REQ-013 Port cfgTopLeftX, input, NUM_TITLES*11 bits: per-channel X origin; channel i occupies slice [11i+10:11i].
REQ-014 Port cfgTopLeftY, input, NUM_TITLES*11 bits: per-channel Y origin; same slicing as cfgTopLeftX.
REQ-015 Port cfgMode, input, NUM_TITLES*2 bits: per-channel mode. 00 = always, 01 = play only, 10 = non-play only, 11 = blink during non-play.
REQ-016 Port romTitleIdx, output, 3 bits: glyph ROM title select.
REQ-017 Port romOffsetX, output, log2(TITLE_W) bits: glyph ROM column.
REQ-018 Port romOffsetY, output, log2(TITLE_H) bits: glyph ROM row.
REQ-019 Port romRGB, input, 8 bits: synchronous ROM data, valid one cycle after the address.
REQ-020 Port titlesDR, output, 1 bit: drawing request.
REQ-021 Port titlesRGB, output, 8 bits: pixel colour.

Function
REQ-022 playGame = ~(gameEnded | standBy), latched into playLatch only on the cycle startOfFrame=1; when both coincide, the new value is taken.
REQ-023 Channel i hits when pixelX is in [X_i, X_i+TITLE_W) and pixelY is in [Y_i, Y_i+TITLE_H); comparisons use 12-bit sums so origins near 2047 never wrap.
REQ-024 Channel i is enabled per mode:
  - 00: always.
  - 01: playLatch=1.
  - 10: playLatch=0.
  - 11: playLatch=0 and blinkPhase=0.
REQ-025 On overlapping enabled hits, the lowest channel index wins.
REQ-026 Stage 1 (edge after pixel cycle N) registers hit, winning index and offsets (pixel minus origin, truncated) onto the rom* outputs.
REQ-027 When there is no hit, rom* outputs hold their previous values.
REQ-028 Stage 2 carries the hit flag alongside the ROM access.
REQ-029 Stage 3 registers titlesDR = hit_d2 & (romRGB != TRANSPARENT) and titlesRGB = romRGB when drawn, else 8'h00.
REQ-030 Total latency from pixelX/pixelY to titlesDR/titlesRGB is exactly 3 clocks, constant with no bubbles.
REQ-031 Blink counter increments on each startOfFrame while playLatch=0 and wraps from BLINK_FRAMES-1 to 0, toggling blinkPhase on wrap.
REQ-032 On a playLatch 1->0 transition, the blink counter and blinkPhase are both cleared to 0, so blinking titles start visible.
REQ-033 While playLatch=1, the blink counter and blinkPhase hold at 0.
REQ-034 Configuration inputs are sampled every cycle; a change takes effect at the pipeline input with no resync.

Reset
REQ-035 While resetN=0 at a rising edge:
  - playLatch=0.
  - Blink counter=0, blinkPhase=0.
  - All pipeline hit flags=0.
  - titlesDR=0, titlesRGB=8'h00.
  - rom* outputs=0.
REQ-036 Reset asserted mid-frame flushes the pipeline: no drawing request appears until 3 clocks after release.
REQ-037 Mode stays non-play after reset until the first startOfFrame.

Structure
REQ-038 Mode encodings, the TRANSPARENT default and the 11-bit coordinate width live in the shared package titles_pkg.
REQ-039 One sub-module, title_hit_detect, performs the per-channel box compare and offset computation, and is instantiated NUM_TITLES times.
REQ-040 The glyph ROM is external to this block.

Verification
REQ-041 Channel 0 at (30,11), mode 00; pixel (30,11); ROM returns 8'h5b -> titlesDR=1, titlesRGB=8'h5b, exactly 3 clocks later.
REQ-042 Pixel (158,11) with TITLE_W=128 -> titlesDR=0, since the right edge is excluded.
REQ-043 Channels 0 and 1 both cover (50,450) -> romTitleIdx=0.
REQ-044 Channel in mode 11, standBy=1, BLINK_FRAMES=2 -> visible for frames 0-1, hidden for frames 2-3, visible again for frames 4-5.
REQ-045 gameEnded rises mid-frame -> mode-01 title keeps drawing until the next startOfFrame, then stops.
REQ-046 resetN=0 for 1 clock while drawing -> titlesDR=0 next cycle; no drawing for 3 clocks after release; playLatch=0.
